// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller: state encoding,
// funct3 load/store codes, strobe patterns and access-size helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Unrecognised funct3 encodings fall back to word accesses.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Combinational load extension: selects the byte/half lane by byte offset and
// sign- or zero-extends it to XLEN.
module mem_access_ctrl_load_ext
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);

  logic [XLEN-1:0] lane;

  assign lane = word >> {offset, 3'b000};

  always_comb begin
    ext = word;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_LH:   ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the shared instruction/data memory port of the multicycle core:
// req/ready handshake, store strobes, load extension, misalign/timeout faults.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_rd,
  input  logic            cpu_wr,
  input  logic [2:0]      cpu_funct3,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]      lat_f3;
  logic [1:0]      lat_off;
  logic [XLEN-1:0] ext_data;
  logic            req;
  size_t           req_size;
  logic            req_misaligned;
  logic [3:0]      strb_next;
  logic [XLEN-1:0] wdata_next;

  assign req            = cpu_rd | cpu_wr;
  assign req_size       = f3_size(cpu_funct3);
  assign req_misaligned = is_misaligned(req_size, cpu_addr[1:0]);

  // Stall covers the request cycle in IDLE plus every BUSY cycle.
  assign stall = (state == ST_BUSY) || ((state == ST_IDLE) && req);

  // Place store data into its byte lanes and build the matching strobes.
  always_comb begin
    strb_next  = STRB_W;
    wdata_next = cpu_wdata;
    case (req_size)
      SZ_BYTE: begin
        strb_next  = STRB_B << cpu_addr[1:0];
        wdata_next = XLEN'({(XLEN/8){cpu_wdata[7:0]}});
      end
      SZ_HALF: begin
        strb_next  = STRB_H << cpu_addr[1:0];
        wdata_next = XLEN'({(XLEN/16){cpu_wdata[15:0]}});
      end
      default: begin
        strb_next  = STRB_W;
        wdata_next = cpu_wdata;
      end
    endcase
  end

  mem_access_ctrl_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3 (lat_f3),
    .offset (lat_off),
    .word   (mem_rdata),
    .ext    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_f3    <= '0;
      lat_off   <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (req_misaligned) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              // Write wins when both requests are raised together.
              state     <= ST_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= cpu_wr;
              mem_addr  <= {cpu_addr[XLEN-1:2], 2'b00};
              mem_wstrb <= cpu_wr ? strb_next : 4'b0000;
              mem_wdata <= wdata_next;
              lat_f3    <= cpu_funct3;
              lat_off   <= cpu_addr[1:0];
              wait_cnt  <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            if (!mem_we) rdata <= ext_data;
            mem_req <= 1'b0;
            state   <= ST_DONE;
            done    <= 1'b1;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            state   <= ST_FAULT;
            fault   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
